// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions used by the transmitter and receiver:
//            frame state encodings and default character/oversample sizes.
// Contents : STATE_W, ST_IDLE..ST_STOP state codes,
//            OVERSAMPLE_DEF (clk ticks per bit per prescale unit),
//            DATA_WIDTH_DEF (bits per character).
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 8;
    localparam int DATA_WIDTH_DEF = 8;

    // Frame sequencer states. Binary-encoded so the receiver can share them.
    localparam int              STATE_W   = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Bit-period timer. On i_load it captures the bit period
//            max(prescale,1)*OVERSAMPLE and counts it down; o_tick pulses for
//            the one cycle the count is zero, after which it reloads.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_load          - start a new bit period from i_prescale
//            i_prescale      - clk cycles per 1/OVERSAMPLE bit
//            o_tick          - last cycle of the current bit period
//            o_pre_tick      - second-to-last cycle of the current bit period
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int PRESCALE_W = 16,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick,
    output logic                  o_pre_tick
);

    // Wide enough for 65535*8-1 without overflow.
    localparam int CNT_W = PRESCALE_W + $clog2(OVERSAMPLE);

    logic [PRESCALE_W-1:0] w_psc;
    logic [CNT_W-1:0]      w_period_m1;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_reload;

    // A prescale of zero would give a zero-length bit; treat it as one.
    assign w_psc       = (i_prescale == '0) ? PRESCALE_W'(1) : i_prescale;
    assign w_period_m1 = (CNT_W'(w_psc) * CNT_W'(OVERSAMPLE)) - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_count  <= w_period_m1;
            r_reload <= w_period_m1;
        end else if (r_count == '0) begin
            r_count  <= r_reload;
        end else begin
            r_count  <= r_count - CNT_W'(1);
        end
    end

    assign o_tick     = (r_count == '0);
    assign o_pre_tick = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/uart_axis_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_axis_tx
// Purpose  : AXI-stream byte sink that serialises each accepted byte onto txd
//            as an asynchronous UART frame (start, data LSB-first, [parity],
//            stop). Bit period = max(prescale,1)*OVERSAMPLE clk cycles.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            s_axis_tdata/tvalid/tready - byte input stream
//            txd                      - serial output, idle high
//            busy                     - frame in progress
//            prescale                 - clk cycles per 1/OVERSAMPLE bit,
//                                       captured when a byte is accepted
// Config   : UART_TX_PARITY_EN - when defined, an even-parity bit is sent
//            between the data bits and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_axis_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [PRESCALE_W-1:0] prescale
);

    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [STATE_W-1:0]    r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_txd;
    logic                  r_ready;
    logic                  r_busy;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic w_accept;
    logic w_tick;
    logic w_pre_tick;

    assign w_accept = s_axis_tvalid & r_ready;

    // The timer is restarted on every accepted byte, which also latches the
    // prescale value for the whole frame.
    uart_baud_tick #(
        .PRESCALE_W (PRESCALE_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_prescale (prescale),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_shift   <= s_axis_tdata;
                        r_bit_idx <= '0;
                        r_txd     <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^s_axis_tdata;
`endif
                    end else begin
                        // Also raises tready on the first edge after reset.
                        r_txd     <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    // tready is registered, so raise it one cycle early to
                    // have it high exactly in the final stop cycle.
                    if (w_pre_tick) begin
                        r_ready <= 1'b1;
                    end
                    if (w_tick) begin
                        if (w_accept) begin
                            // Chain straight into the next frame, no idle gap.
                            r_state   <= ST_START;
                            r_shift   <= s_axis_tdata;
                            r_bit_idx <= '0;
                            r_txd     <= 1'b0;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                            r_parity  <= ^s_axis_tdata;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = r_ready;
    assign txd           = r_txd;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_axis_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_axis_tx
// Purpose  : Directed self-checking bench for uart_axis_tx. Frames are
//            captured cycle by cycle after the accepting clock edge and
//            compared with hand-derived start/data/[parity]/stop patterns.
// Config   : UART_TX_PARITY_EN - when defined, frames carry an even-parity
//            bit and the parity scenario is exercised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_axis_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [15:0] prescale;

    int n_cmp = 0;
    int n_err = 0;

    logic cap_txd  [0:511];
    logic cap_busy [0:511];
    logic cap_rdy  [0:511];

    uart_axis_tx dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale)
    );

    always #5 clk = ~clk;

    // Expected txd level for bit slot b of a frame carrying byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Present a byte and wait (bounded) for the accepting edge; returns #1
    // after that edge, i.e. in the first cycle of the new frame.
    task automatic handshake(input logic [7:0] d);
        bit r;
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = s_axis_tready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL handshake 0x%02h: tready got 0, expected 1 within 200 cycles", d);
        end
    endtask

    // Record n cycles of outputs. tvalid drops after the edge that follows
    // sample hold_until; prescale changes to chg_val at sample chg_idx.
    task automatic capture(input int n, input int hold_until,
                           input int chg_idx, input logic [15:0] chg_val);
        for (int k = 0; k < n; k++) begin
            cap_txd[k]  = txd;
            cap_busy[k] = busy;
            cap_rdy[k]  = s_axis_tready;
            if (k == chg_idx) prescale = chg_val;
            @(posedge clk); #1;
            if (k == hold_until) s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        prescale      = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b expected 0", s_axis_tready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL release_tready: got %b expected 0 before first edge", s_axis_tready); end
        @(posedge clk); #1;
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL first_edge_tready: got %b expected 1", s_axis_tready); end
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if (txd !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_quiet cycle %0d: txd=%b busy=%b expected txd=1 busy=0", k, txd, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_frame;
        localparam int T = 8;
        int f;
        f = NBITS * T;
        prescale = 16'd1;
        handshake(8'h55);
        s_axis_tvalid = 1'b0;
        capture(f, -1, -1, 16'd0);
        for (int k = 0; k < f; k++) begin
            n_cmp++;
            if (cap_txd[k] !== exp_bit(8'h55, k / T)) begin
                n_err++; $display("FAIL single_txd cycle %0d: got %b expected %b", k, cap_txd[k], exp_bit(8'h55, k / T));
            end
            n_cmp++;
            if (cap_busy[k] !== 1'b1) begin
                n_err++; $display("FAIL single_busy cycle %0d: got %b expected 1", k, cap_busy[k]);
            end
            n_cmp++;
            if (cap_rdy[k] !== (k == f - 1)) begin
                n_err++; $display("FAIL single_tready cycle %0d: got %b expected %b", k, cap_rdy[k], (k == f - 1));
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy: got %b expected 0", busy); end
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL single_end_txd: got %b expected 1", txd); end
        n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL single_end_tready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_back_to_back;
        localparam int T = 8;
        int f;
        logic e;
        f = NBITS * T;
        prescale = 16'd1;
        handshake(8'hA5);
        s_axis_tdata = 8'h3C;   // tvalid stays high: second byte waits for stop
        capture(2 * f, f - 1, -1, 16'd0);
        for (int k = 0; k < 2 * f; k++) begin
            e = (k < f) ? exp_bit(8'hA5, k / T) : exp_bit(8'h3C, (k - f) / T);
            n_cmp++;
            if (cap_txd[k] !== e) begin
                n_err++; $display("FAIL b2b_txd cycle %0d: got %b expected %b", k, cap_txd[k], e);
            end
            n_cmp++;
            if (cap_busy[k] !== 1'b1) begin
                n_err++; $display("FAIL b2b_busy cycle %0d: got %b expected 1", k, cap_busy[k]);
            end
            n_cmp++;
            if (cap_rdy[k] !== ((k == f - 1) || (k == 2 * f - 1))) begin
                n_err++; $display("FAIL b2b_tready cycle %0d: got %b", k, cap_rdy[k]);
            end
        end
        n_cmp++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL b2b_end: busy=%b txd=%b expected 0/1", busy, txd); end
    endtask

    task automatic test_reset_mid_frame;
        localparam int T = 8;
        int f;
        f = NBITS * T;
        prescale = 16'd1;
        handshake(8'hFF);
        s_axis_tvalid = 1'b0;
        capture(29, -1, -1, 16'd0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_abort_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL abort_txd: got %b expected 1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL abort_tready: got %b expected 0", s_axis_tready); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (s_axis_tready !== 1'b1 || txd !== 1'b1) begin n_err++; $display("FAIL post_abort_idle: tready=%b txd=%b expected 1/1", s_axis_tready, txd); end
        handshake(8'h01);
        s_axis_tvalid = 1'b0;
        capture(f, -1, -1, 16'd0);
        for (int k = 0; k < f; k++) begin
            n_cmp++;
            if (cap_txd[k] !== exp_bit(8'h01, k / T) || cap_busy[k] !== 1'b1) begin
                n_err++; $display("FAIL after_abort cycle %0d: txd=%b busy=%b expected txd=%b busy=1", k, cap_txd[k], cap_busy[k], exp_bit(8'h01, k / T));
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL after_abort_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_prescale;
        int f;
        // prescale 0 behaves as 1: T = 8
        f = NBITS * 8;
        prescale = 16'd0;
        handshake(8'h80);
        s_axis_tvalid = 1'b0;
        capture(f, -1, -1, 16'd0);
        for (int k = 0; k < f; k++) begin
            n_cmp++;
            if (cap_txd[k] !== exp_bit(8'h80, k / 8) || cap_busy[k] !== 1'b1) begin
                n_err++; $display("FAIL psc0 cycle %0d: txd=%b busy=%b expected txd=%b busy=1", k, cap_txd[k], cap_busy[k], exp_bit(8'h80, k / 8));
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL psc0_end_busy: got %b expected 0", busy); end
        // prescale 3 (T = 24) changed to 5 mid-frame must not affect this frame
        f = NBITS * 24;
        prescale = 16'd3;
        handshake(8'h5A);
        s_axis_tvalid = 1'b0;
        capture(f, -1, 10, 16'd5);
        for (int k = 0; k < f; k++) begin
            n_cmp++;
            if (cap_txd[k] !== exp_bit(8'h5A, k / 24) || cap_busy[k] !== 1'b1) begin
                n_err++; $display("FAIL psc3 cycle %0d: txd=%b busy=%b expected txd=%b busy=1", k, cap_txd[k], cap_busy[k], exp_bit(8'h5A, k / 24));
            end
        end
        n_cmp++; if (busy !== 1'b0 || txd !== 1'b1) begin n_err++; $display("FAIL psc3_end: busy=%b txd=%b expected 0/1", busy, txd); end
        prescale = 16'd1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int f;
        f = NBITS * 8;
        prescale = 16'd1;
        handshake(8'h07);
        s_axis_tvalid = 1'b0;
        capture(f, -1, -1, 16'd0);
        n_cmp++; if (cap_txd[9 * 8 + 4] !== 1'b1) begin n_err++; $display("FAIL parity_07: got %b expected 1", cap_txd[9 * 8 + 4]); end
        n_cmp++; if (cap_txd[f - 1] !== 1'b1 || cap_busy[f - 1] !== 1'b1) begin n_err++; $display("FAIL parity_07_stop: txd=%b busy=%b expected 1/1", cap_txd[f - 1], cap_busy[f - 1]); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL parity_07_len: busy got %b expected 0 after 88 cycles", busy); end
        handshake(8'h03);
        s_axis_tvalid = 1'b0;
        capture(f, -1, -1, 16'd0);
        n_cmp++; if (cap_txd[9 * 8 + 4] !== 1'b0) begin n_err++; $display("FAIL parity_03: got %b expected 0", cap_txd[9 * 8 + 4]); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL parity_03_len: busy got %b expected 0 after 88 cycles", busy); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_reset_mid_frame;
        test_prescale;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
